// File: rtl/fwrisc_rf_wr_arb.sv
// Purpose : single write-port arbiter for the 64-entry register file (GPR 0-31, CSR shadow 32-63).
// Latency : grant in cycle N, rf_wen/rf_waddr/rf_wdata valid in cycle N+1 for one cycle.
// Backpr. : valid/grant; a losing requester holds req/addr/data until its gnt, starvation counter bounds ctr wait.
//
// Optional feature macro: FWRISC_RF_ARB_DBG_PORT_EN adds the dbg_* requester with top priority.
//
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   ex_req/ex_addr/ex_data       exec writeback requester          -> ex_gnt
//   ctr_req/ctr_addr/ctr_data    CSR counter updater (mcycle etc.) -> ctr_gnt
//   dbg_req/dbg_addr/dbg_data    debug requester (macro only)      -> dbg_gnt
//   rf_wen/rf_waddr/rf_wdata     registered register-file write port
//   starved                      counter requester currently outranks exec
module fwrisc_rf_wr_arb #(
    parameter int STARVE_LIMIT = 4      // legal range 1-15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_req,
    input  logic [5:0]  ex_addr,
    input  logic [31:0] ex_data,
    output logic        ex_gnt,
    input  logic        ctr_req,
    input  logic [5:0]  ctr_addr,
    input  logic [31:0] ctr_data,
    output logic        ctr_gnt,
`ifdef FWRISC_RF_ARB_DBG_PORT_EN
    input  logic        dbg_req,
    input  logic [5:0]  dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_gnt,
`endif
    output logic        rf_wen,
    output logic [5:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        starved
);

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } wr_req_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic        dbg_req_i;
    wr_req_t     dbg_wr;
    logic        dbg_gnt_i;
    wr_req_t     win_wr;
    logic        any_gnt;
    logic [3:0]  starve_cnt;

`ifdef FWRISC_RF_ARB_DBG_PORT_EN
    assign dbg_req_i = dbg_req;
    assign dbg_wr    = '{addr: dbg_addr, data: dbg_data};
    assign dbg_gnt   = dbg_gnt_i;
`else
    // Without the debug port the debug lane is tied off and never wins.
    assign dbg_req_i = 1'b0;
    assign dbg_wr    = '0;
`endif

    assign starved = (starve_cnt == STARVE_MAX);

    // Combinational grant. Debug always first; exec and counter swap
    // places while the counter has been starved. Reset masks all grants
    // so nothing is accepted that the write stage would then drop.
    always_comb begin
        ex_gnt    = 1'b0;
        ctr_gnt   = 1'b0;
        dbg_gnt_i = 1'b0;
        if (!reset) begin
            if (dbg_req_i) begin
                dbg_gnt_i = 1'b1;
            end else if (starved) begin
                if (ctr_req)     ctr_gnt = 1'b1;
                else if (ex_req) ex_gnt  = 1'b1;
            end else begin
                if (ex_req)       ex_gnt  = 1'b1;
                else if (ctr_req) ctr_gnt = 1'b1;
            end
        end
    end

    // Winner mux: grants are one-hot so a simple priority select suffices.
    always_comb begin
        win_wr  = '0;
        any_gnt = dbg_gnt_i | ex_gnt | ctr_gnt;
        if (dbg_gnt_i)    win_wr = dbg_wr;
        else if (ex_gnt)  win_wr = '{addr: ex_addr, data: ex_data};
        else if (ctr_gnt) win_wr = '{addr: ctr_addr, data: ctr_data};
    end

    // Starvation counter: counts cycles the counter requester waits,
    // saturating at the limit. A debug win while saturated leaves it
    // saturated so the counter still beats exec next time.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!ctr_req || ctr_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Write stage. Writes to x0 still consume the slot but never assert
    // rf_wen, so the decode hazard check never sees a pending x0 write.
    always_ff @(posedge clock) begin
        if (reset) begin
            rf_wen   <= 1'b0;
            rf_waddr <= 6'd0;
            rf_wdata <= 32'd0;
        end else if (any_gnt) begin
            rf_wen   <= (win_wr.addr != 6'd0);
            rf_waddr <= win_wr.addr;
            rf_wdata <= win_wr.data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fwrisc_rf_wr_arb.sv
module tb_fwrisc_rf_wr_arb;

    localparam int LIM = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_req, ctr_req, dbg_req;
    logic [5:0]  ex_addr, ctr_addr, dbg_addr;
    logic [31:0] ex_data, ctr_data, dbg_data;
    logic        ex_gnt, ctr_gnt, dbg_gnt;
    logic        rf_wen;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        starved;

    always #5 clock = ~clock;

    fwrisc_rf_wr_arb #(.STARVE_LIMIT(LIM)) dut (
        .clock    (clock),
        .reset    (reset),
        .ex_req   (ex_req),
        .ex_addr  (ex_addr),
        .ex_data  (ex_data),
        .ex_gnt   (ex_gnt),
        .ctr_req  (ctr_req),
        .ctr_addr (ctr_addr),
        .ctr_data (ctr_data),
        .ctr_gnt  (ctr_gnt),
`ifdef FWRISC_RF_ARB_DBG_PORT_EN
        .dbg_req  (dbg_req),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .dbg_gnt  (dbg_gnt),
`endif
        .rf_wen   (rf_wen),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .starved  (starved)
    );

`ifndef FWRISC_RF_ARB_DBG_PORT_EN
    assign dbg_gnt = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: waiting-cycle count of the counter requester
    // and the last write presented to the register file.
    int          m_cnt  = 0;
    logic        m_wen  = 1'b0;
    logic [5:0]  m_addr = 6'd0;
    logic [31:0] m_data = 32'd0;

    // Results of the most recent step: model winner and DUT samples.
    int   w_last;
    logic s_ex_gnt, s_ctr_gnt, s_dbg_gnt, s_starved;

    // One clock cycle: drive requests, check grants mid-cycle against the
    // priority list, advance the model, then check the registered write.
    task automatic step(input bit rst,
                        input bit e, input logic [5:0] ea, input logic [31:0] ed,
                        input bit c, input logic [5:0] ca, input logic [31:0] cd,
                        input bit d, input logic [5:0] da, input logic [31:0] dd);
        bit          reqv[3];
        logic [5:0]  av[3];
        logic [31:0] dv[3];
        int          order[3];
        bit          m_starved;
        int          winner;
        reset = rst;
        ex_req = e;  ex_addr = ea;  ex_data = ed;
        ctr_req = c; ctr_addr = ca; ctr_data = cd;
        dbg_req = d; dbg_addr = da; dbg_data = dd;
`ifdef FWRISC_RF_ARB_DBG_PORT_EN
        reqv[0] = d;
`else
        reqv[0] = 1'b0;
`endif
        reqv[1] = e; reqv[2] = c;
        av[0] = da; av[1] = ea; av[2] = ca;
        dv[0] = dd; dv[1] = ed; dv[2] = cd;
        m_starved = (m_cnt == LIM);
        // 0 = dbg, 1 = ex, 2 = ctr, listed highest priority first
        if (m_starved) order = '{0, 2, 1};
        else           order = '{0, 1, 2};
        winner = -1;
        if (!rst)
            foreach (order[k])
                if (winner < 0 && reqv[order[k]]) winner = order[k];
        #1;
        chk("ex_gnt",  32'(ex_gnt),  32'(winner == 1));
        chk("ctr_gnt", 32'(ctr_gnt), 32'(winner == 2));
`ifdef FWRISC_RF_ARB_DBG_PORT_EN
        chk("dbg_gnt", 32'(dbg_gnt), 32'(winner == 0));
`endif
        chk("starved", 32'(starved), 32'(m_starved));
        s_ex_gnt = ex_gnt; s_ctr_gnt = ctr_gnt; s_dbg_gnt = dbg_gnt; s_starved = starved;
        w_last = winner;
        if (rst) begin
            m_cnt = 0; m_wen = 1'b0; m_addr = 6'd0; m_data = 32'd0;
        end else begin
            if (winner >= 0) begin
                m_wen  = (av[winner] != 6'd0);
                m_addr = av[winner];
                m_data = dv[winner];
            end else begin
                m_wen = 1'b0;
            end
            if (!c || winner == 2) m_cnt = 0;
            else if (m_cnt < LIM)  m_cnt = m_cnt + 1;
        end
        @(posedge clock);
        #1;
        chk("rf_wen",   32'(rf_wen),   32'(m_wen));
        chk("rf_waddr", 32'(rf_waddr), 32'(m_addr));
        chk("rf_wdata", rf_wdata,      m_data);
    endtask

    task automatic idle(input bit rst);
        step(rst, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
    endtask

    initial begin
        bit          ep, cp, dp, cdone, rst;
        logic [5:0]  ea, ca, da;
        logic [31:0] ed, cd, dd;

        reset = 1'b1;
        ex_req = 0; ctr_req = 0; dbg_req = 0;
        ex_addr = 0; ctr_addr = 0; dbg_addr = 0;
        ex_data = 0; ctr_data = 0; dbg_data = 0;
        @(posedge clock);
        #1;

        // Reset held two cycles with every requester active.
        for (int i = 0; i < 2; i++) begin
            step(1, 1, 6'd3, 32'h11, 1, 6'h20, 32'h22, 1, 6'd4, 32'h33);
            chk("rst_ex_gnt", 32'(s_ex_gnt), 32'd0);
            chk("rst_ctr_gnt", 32'(s_ctr_gnt), 32'd0);
            chk("rst_dbg_gnt", 32'(s_dbg_gnt), 32'd0);
        end
        idle(0);
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_starved", 32'(s_starved), 32'd0);

        // Single exec write, then the write pulse ends.
        step(0, 1, 6'd5, 32'hDEADBEEF, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
        chk("single_gnt", 32'(s_ex_gnt), 32'd1);
        chk("single_wen", 32'(rf_wen), 32'd1);
        chk("single_waddr", 32'(rf_waddr), 32'd5);
        chk("single_wdata", rf_wdata, 32'hDEADBEEF);
        idle(0);
        chk("single_wen_off", 32'(rf_wen), 32'd0);

        // Write to x0 is granted but never enables the register file.
        step(0, 1, 6'd0, 32'h1234, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0);
        chk("x0_gnt", 32'(s_ex_gnt), 32'd1);
        chk("x0_wen", 32'(rf_wen), 32'd0);

        // Starvation: exec every cycle, counter waits LIM cycles then wins.
        cdone = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 6'(i + 1), 32'(i), !cdone, 6'h20, 32'd7, 0, 6'd0, 32'd0);
            if (s_ctr_gnt) cdone = 1;
            if (i < 4) begin
                chk("stv_ex_gnt", 32'(s_ex_gnt), 32'd1);
                chk("stv_starved_lo", 32'(s_starved), 32'd0);
            end else if (i == 4) begin
                chk("stv_starved_hi", 32'(s_starved), 32'd1);
                chk("stv_ctr_gnt", 32'(s_ctr_gnt), 32'd1);
                chk("stv_ex_lose", 32'(s_ex_gnt), 32'd0);
                chk("stv_waddr", 32'(rf_waddr), 32'h20);
                chk("stv_wdata", rf_wdata, 32'd7);
            end else begin
                chk("stv_ex_again", 32'(s_ex_gnt), 32'd1);
            end
        end
        idle(0);

`ifdef FWRISC_RF_ARB_DBG_PORT_EN
        // Debug first, then exec, then counter on consecutive cycles.
        ep = 1; cp = 1; dp = 1;
        for (int i = 0; i < 3; i++) begin
            step(0, ep, 6'd4, 32'hE0, cp, 6'h22, 32'hC0, dp, 6'd3, 32'hD0);
            if (s_dbg_gnt) dp = 0;
            if (s_ex_gnt)  ep = 0;
            if (s_ctr_gnt) cp = 0;
            case (i)
                0: chk("dbg_order0", 32'(rf_waddr), 32'd3);
                1: chk("dbg_order1", 32'(rf_waddr), 32'd4);
                default: chk("dbg_order2", 32'(rf_waddr), 32'h22);
            endcase
        end
        idle(0);
`endif

        // Counter request abandoned after two losing cycles.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 6'd9, 32'(i), i < 2, 6'h21, 32'hAB, 0, 6'd0, 32'd0);
            if (i >= 2) chk("abandon_starved", 32'(s_starved), 32'd0);
            chk("abandon_nowrite", 32'(rf_wen && rf_waddr == 6'h21), 32'd0);
        end
        idle(0);

        // Randomised traffic against the model.
        ep = 0; cp = 0; dp = 0;
        ea = 0; ca = 0; da = 0; ed = 0; cd = 0; dd = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (!ep && $urandom_range(0, 99) < 85) begin
                ep = 1;
                ea = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(0, 31));
                ed = $urandom;
            end else if (ep && $urandom_range(0, 99) < 3) begin
                ep = 0;
            end
            if (!cp && $urandom_range(0, 99) < 50) begin
                cp = 1; ca = 6'(32 + $urandom_range(0, 31)); cd = $urandom;
            end else if (cp && $urandom_range(0, 99) < 4) begin
                cp = 0;
            end
            if (!dp && $urandom_range(0, 99) < 8) begin
                dp = 1; da = 6'($urandom_range(0, 63)); dd = $urandom;
            end
            step(rst, ep, ea, ed, cp, ca, cd, dp, da, dd);
            if (w_last == 1) ep = 0;
            if (w_last == 2) cp = 0;
            if (w_last == 0) dp = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard bound on total run time.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fwrisc_rf_wr_arb.md
# fwrisc_rf_wr_arb

Write-port arbiter for the shared 64-entry register file (GPRs at 0–31, CSR shadow registers at 32–63). It shares the single write port between the exec writeback path and the CSR counter updater (mcycle/minstret), and optionally a debug requester. A starvation counter guarantees counter updates progress under back-to-back exec writebacks. The write is registered, so the register file sees exactly one write per cycle, one cycle after grant.

## Interface
- STARVE_LIMIT, 4, cycles a pending counter request may lose to exec before it is forced to win; legal range 1–15
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ex_req  in  1  exec writeback request
- ex_addr  in  6  exec destination register address
- ex_data  in  32  exec writeback data
- ex_gnt  out  1  exec request accepted this cycle
- ctr_req  in  1  counter-update request
- ctr_addr  in  6  counter CSR address
- ctr_data  in  32  counter value
- ctr_gnt  out  1  counter request accepted this cycle
- dbg_req / dbg_addr / dbg_data / dbg_gnt  in/in/in/out  1/6/32/1  debug write requester; present only with FWRISC_RF_ARB_DBG_PORT_EN
- rf_wen  out  1  register-file write enable
- rf_waddr  out  6  register-file write address
- rf_wdata  out  32  register-file write data
- starved  out  1  starvation counter at STARVE_LIMIT; counter currently has priority over exec

## Operation
- Valid/grant handshake: a requester holds req, addr and data stable until it sees gnt high. A transfer occurs in any cycle where req and gnt are both high. Dropping req before gnt is legal and abandons the request.
- Grants are combinational from the reqs and the starve state. At most one gnt is high per cycle.
- Normal priority: dbg > ex > ctr.
- Starve counter: 4-bit, reset 0.
  - Increments, saturating at STARVE_LIMIT, in each cycle where ctr_req is high and ctr_gnt is low.
  - Clears to 0 in any cycle where ctr_gnt is high or ctr_req is low.
- starved = (counter == STARVE_LIMIT). While starved, priority becomes dbg > ctr > ex.
- Write stage: on any grant, the winner's addr and data are registered into rf_waddr/rf_wdata next cycle. rf_wen is registered high, except when the winner's addr == 0 (x0), where rf_wen stays 0. The x0 request is still granted and consumes the slot.
- With no grant, rf_wen goes to 0 next cycle. rf_waddr and rf_wdata hold their last values.

## Timing
- Reset values: rf_wen=0, rf_waddr=0, rf_wdata=0, starved=0, starve counter=0.
- While reset is high, all gnt outputs are forced to 0.
- Reset asserted in the same cycle as a grant: the gnt is suppressed, nothing is written, and the requester must retry after reset.
- Latency: grant in cycle N gives rf_wen/rf_waddr/rf_wdata valid in cycle N+1 for exactly one cycle.
- Throughput: one write per cycle, with no bubbles between consecutive grants to the same or different requesters.
- Simultaneous ex_req and ctr_req while counter < STARVE_LIMIT: ex wins and the counter increments.
- Simultaneous ex_req and ctr_req while starved: ctr wins, the counter clears, and ex is granted the following cycle if it still requests.
- dbg_req at the same time as a starved ctr_req: dbg wins and the counter stays saturated.
- The decode stage uses rf_wen/rf_waddr as the pending-write indication for hazard detection. The register file does not bypass a write into a same-cycle read.

## Configuration
- FWRISC_RF_ARB_DBG_PORT_EN defined: the dbg_* ports exist and dbg has highest priority.
- FWRISC_RF_ARB_DBG_PORT_EN undefined: the dbg_* ports are absent and priority is ex > ctr, with the starvation override unchanged.

## Test plan
- Reset check: hold reset 2 cycles with all reqs high. All gnts are 0 throughout. After release, rf_wen=0, rf_waddr=0, rf_wdata=0, starved=0.
- Single exec write: ex_req=1, ex_addr=5, ex_data=0xDEADBEEF for one cycle. ex_gnt=1 that cycle. Next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF. The cycle after, rf_wen=0.
- x0 suppression: ex_addr=0, ex_data=0x1234. ex_gnt=1, and rf_wen stays 0 the next cycle.
- Starvation with STARVE_LIMIT=4: ex_req held high continuously, ctr_req=1 with ctr_addr=0x20 and ctr_data=7 from cycle 0. ex is granted in cycles 0–3 and starved=1 in cycle 4. In cycle 4 ctr_gnt=1 and ex_gnt=0; in cycle 5 rf_waddr=0x20, rf_wdata=7, and ex is granted again.
- Debug priority (macro on): dbg_req, ex_req and ctr_req all high. dbg_gnt=1 only, then ex, then ctr. rf_waddr follows the same order on consecutive cycles.
- Abandoned request: ctr_req high for 2 cycles under exec traffic, then dropped. The counter clears, starved=0, and no ctr write appears.
